// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and write-back.
// Issues one load or store per request to a single-port synchronous RAM
// with a fixed read latency. Load data returns with a load_finish pulse,
// stores complete with a store_finish pulse, and misaligned requests are
// rejected with a misaligned pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | no request in flight, ready to accept
// S_READ_WAIT | load issued, counting down the RAM read latency
// S_FINISH    | previous request completed this cycle, ready to accept
module mem_access #(
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic              i_req_store,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_req_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_rdata,
  output logic              o_load_finish,
  output logic              o_store_finish,
  output logic              o_misaligned
);

  // Counter must hold the value RD_LAT itself.
  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_WAIT = 2'd1,
    S_FINISH    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_we;
  logic [31:0]        r_rdata;
  logic               r_load_finish;
  logic               r_store_finish;
  logic               r_misaligned;

  logic               w_ready;
  logic               w_accept;
  logic               w_misal;
  logic               w_cnt_zero;
  logic [ADDR_W-1:0]  w_word_addr;
  logic               w_addr_unused;

  assign w_accept    = i_req_valid && w_ready;
  assign w_misal     = |i_req_addr[1:0];
  assign w_cnt_zero  = (r_cnt == '0);
  // Upper byte-address bits are dropped: addresses wrap modulo 2^ADDR_W words.
  assign w_word_addr = i_req_addr[ADDR_W+1:2];
  assign w_addr_unused = ^i_req_addr[31:ADDR_W+2];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: FINISH accepts exactly like IDLE so requests can stream.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FINISH: begin
        if (w_accept) begin
          if (w_misal || i_req_store) w_state_nxt = S_FINISH;
          else                        w_state_nxt = S_READ_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ_WAIT: begin
        if (w_cnt_zero) w_state_nxt = S_FINISH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: the stage is only busy while a load waits on the RAM.
  always_comb begin
    w_ready = 1'b1;
    if (r_state == S_READ_WAIT) w_ready = 1'b0;
  end

  // Datapath: RAM request registers, latency counter, load capture and pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_we       <= 1'b0;
      r_rdata        <= '0;
      r_load_finish  <= 1'b0;
      r_store_finish <= 1'b0;
      r_misaligned   <= 1'b0;
    end else begin
      r_mem_we       <= 1'b0;
      r_load_finish  <= 1'b0;
      r_store_finish <= 1'b0;
      r_misaligned   <= 1'b0;

      if (w_accept) begin
        if (w_misal) begin
          // Rejected: RAM address/data and rdata are left untouched.
          r_misaligned <= 1'b1;
        end else if (i_req_store) begin
          r_mem_addr     <= w_word_addr;
          r_mem_wdata    <= i_req_wdata;
          r_mem_we       <= 1'b1;
          r_store_finish <= 1'b1;
        end else begin
          r_mem_addr <= w_word_addr;
          r_cnt      <= CNT_W'(RD_LAT);
        end
      end

      // Address is held for RD_LAT+1 cycles; data is captured on the last one.
      if (r_state == S_READ_WAIT) begin
        if (w_cnt_zero) begin
          r_rdata       <= i_mem_rdata;
          r_load_finish <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_req_ready    = w_ready;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_we       = r_mem_we;
  assign o_rdata        = r_rdata;
  assign o_load_finish  = r_load_finish;
  assign o_store_finish = r_store_finish;
  assign o_misaligned   = r_misaligned;

endmodule
